// File: rtl/note_sequencer.sv
// Melody sequencer: walks an external synchronous note ROM and drives the tone generator.
// Optional macro SEQ_ARTICULATION_EN inserts GAP_TICKS silent cycles after every note.
module note_sequencer #(
  parameter int ADDR_W       = 6,
  parameter int TICKS_PER_MS = 32,
  parameter int GAP_TICKS    = 320
) (
  input  logic              CLK_32KHz,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loopEnable,
  output logic [ADDR_W-1:0] noteAddr,
  input  logic [23:0]       noteData,
  output logic [13:0]       outputFrequency,
  output logic              noteGate,
  output logic              busy,
  output logic              done
);

  localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
`ifdef SEQ_ARTICULATION_EN
    S_GAP,
`endif
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [13:0]       r_freq;
  logic              r_gate;
  logic              r_busy;
  logic              r_done;
  logic [9:0]        r_ms;
  logic [TW-1:0]     r_tick;
`ifdef SEQ_ARTICULATION_EN
  logic [GW-1:0]     r_gap;
`endif

  logic [13:0] w_freq;
  logic [9:0]  w_dur;
  logic        w_last;
  logic        w_wrap;

  assign w_freq = noteData[23:10];
  assign w_dur  = noteData[9:0];
  assign w_last = (r_addr == {ADDR_W{1'b1}});
  assign w_wrap = (r_tick == TW'(TICKS_PER_MS - 1));

  assign noteAddr        = r_addr;
  assign outputFrequency = r_freq;
  assign noteGate        = r_gate;
  assign busy            = r_busy;
  assign done            = r_done;

  always_ff @(posedge CLK_32KHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_freq  <= '0;
      r_gate  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ms    <= '0;
      r_tick  <= '0;
`ifdef SEQ_ARTICULATION_EN
      r_gap   <= '0;
`endif
    end else if (stop) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_freq  <= '0;
      r_gate  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ms    <= '0;
      r_tick  <= '0;
`ifdef SEQ_ARTICULATION_EN
      r_gap   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FETCH;
            r_addr  <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          if (w_dur == 10'd0) begin
            if (loopEnable) begin
              r_state <= S_FETCH;
              r_addr  <= '0;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_freq  <= '0;
              r_gate  <= 1'b0;
            end
          end else begin
            r_state <= S_PLAY;
            r_freq  <= w_freq;
            r_gate  <= (w_freq != 14'd0);
            r_ms    <= w_dur;
            r_tick  <= '0;
          end
        end
        S_PLAY: begin
          if (w_wrap) begin
            r_tick <= '0;
            r_ms   <= r_ms - 10'd1;
            if (r_ms == 10'd1) begin
              // Last table slot acts as an implicit end marker; address rolls back to 0.
              if (w_last) begin
                r_addr <= '0;
                if (loopEnable) begin
                  r_state <= S_FETCH;
                end else begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_freq  <= '0;
                  r_gate  <= 1'b0;
                end
              end else begin
                r_addr <= r_addr + 1'b1;
`ifdef SEQ_ARTICULATION_EN
                r_state <= S_GAP;
                r_gap   <= '0;
                r_freq  <= '0;
                r_gate  <= 1'b0;
`else
                r_state <= S_FETCH;
`endif
              end
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
`ifdef SEQ_ARTICULATION_EN
        S_GAP: begin
          if (r_gap == GW'(GAP_TICKS - 1)) begin
            r_state <= S_FETCH;
            r_gap   <= '0;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
`endif
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: expected output-change events (value plus cycle spacing)
// are queued by the stimulus and popped by a monitor whenever the DUT outputs change.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loopEnable = 1'b0;
  logic [5:0]  noteAddr;
  logic [23:0] noteData;
  logic [13:0] outputFrequency;
  logic        noteGate, busy, done;

  note_sequencer #(.ADDR_W(6), .TICKS_PER_MS(32), .GAP_TICKS(320)) dut (
    .CLK_32KHz(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .loopEnable(loopEnable), .noteAddr(noteAddr), .noteData(noteData),
    .outputFrequency(outputFrequency), .noteGate(noteGate), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [23:0] rom [64];
  always_ff @(posedge clk) noteData <= rom[noteAddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [22:0] sig;
    int          dt;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic        mon_en = 1'b0;
  logic [22:0] prev;
  int          last;

  function automatic logic [22:0] cur_sig();
    return {noteAddr, outputFrequency, noteGate, busy, done};
  endfunction

  task automatic push(input int a, input int f, input bit g, input bit b, input bit d, input int dt);
    exp_t e;
    e.sig = {a[5:0], f[13:0], g, b, d};
    e.dt  = dt;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic [22:0] s;
      s = cur_sig();
      if (s !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d got addr=%0d freq=%0d gate=%0b busy=%0b done=%0b",
                   cyc, s[22:17], s[16:3], s[2], s[1], s[0]);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (s !== e.sig || (e.dt >= 0 && (cyc - last) != e.dt)) begin
            errors++;
            $display("FAIL event cyc=%0d got sig=%h dt=%0d expected sig=%h dt=%0d",
                     cyc, s, cyc - last, e.sig, e.dt);
          end
        end
        last = cyc;
        prev = s;
      end
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 24'd0;
  endtask

  function automatic logic [23:0] note(input int f, input int ms);
    return {f[13:0], ms[9:0]};
  endfunction

  task automatic pulse_start(output int e);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    e = cyc;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic stop_at(input int t);
    wait_until(t - 1);
    stop = 1'b1;
    @(negedge clk) stop = 1'b0;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events not seen, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic check_val(input string name, input logic [22:0] got, input logic [22:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  int E, S;

  initial begin
    clear_rom();
    repeat (3) @(negedge clk);
    check_val("reset_state", cur_sig(), 23'd0);
    reset_n = 1'b1;
    @(negedge clk);
    prev   = cur_sig();
    last   = cyc;
    mon_en = 1'b1;

    // T1: single 440 Hz note of 2 ms
    clear_rom();
    rom[0] = note(440, 2);
    push(0, 0, 0, 1, 0, -1);
    push(0, 440, 1, 1, 0, 2);
`ifdef SEQ_ARTICULATION_EN
    push(1, 0, 0, 1, 0, 64);
    push(1, 0, 0, 1, 1, 322);
    push(1, 0, 0, 0, 0, 1);
    pulse_start(E);
    wait_until(E + 395);
`else
    push(1, 440, 1, 1, 0, 64);
    push(1, 0, 0, 1, 1, 2);
    push(1, 0, 0, 0, 0, 1);
    pulse_start(E);
    wait_until(E + 75);
`endif
    check_drained("t1_single_note");

    // T2: note, rest, note, end marker
    clear_rom();
    rom[0] = note(262, 1);
    rom[1] = note(0, 1);
    rom[2] = note(330, 1);
    push(0, 0, 0, 1, 0, -1);
    push(0, 262, 1, 1, 0, 2);
`ifdef SEQ_ARTICULATION_EN
    push(1, 0, 0, 1, 0, 32);
    push(2, 0, 0, 1, 0, 354);
    push(2, 330, 1, 1, 0, 322);
    push(3, 0, 0, 1, 0, 32);
    push(3, 0, 0, 1, 1, 322);
    push(3, 0, 0, 0, 0, 1);
    pulse_start(E);
    wait_until(E + 1070);
`else
    push(1, 262, 1, 1, 0, 32);
    push(1, 0, 0, 1, 0, 2);
    push(2, 0, 0, 1, 0, 32);
    push(2, 330, 1, 1, 0, 2);
    push(3, 330, 1, 1, 0, 32);
    push(3, 0, 0, 1, 1, 2);
    push(3, 0, 0, 0, 0, 1);
    pulse_start(E);
    wait_until(E + 110);
`endif
    check_drained("t2_rest_sequence");

    // T3: looping single note, then stop
    clear_rom();
    rom[0] = note(500, 1);
    loopEnable = 1'b1;
    push(0, 0, 0, 1, 0, -1);
    push(0, 500, 1, 1, 0, 2);
`ifdef SEQ_ARTICULATION_EN
    push(1, 0, 0, 1, 0, 32);
    push(0, 0, 0, 1, 0, 322);
    push(0, 500, 1, 1, 0, 2);
    push(1, 0, 0, 1, 0, 32);
    push(0, 0, 0, 0, 0, 10);
    S = 400;
`else
    push(1, 500, 1, 1, 0, 32);
    push(0, 500, 1, 1, 0, 2);
    push(1, 500, 1, 1, 0, 34);
    push(0, 500, 1, 1, 0, 2);
    push(0, 0, 0, 0, 0, 28);
    S = 100;
`endif
    pulse_start(E);
    stop_at(E + S);
    loopEnable = 1'b0;
    wait_until(E + S + 10);
    check_drained("t3_loop_stop");
    check_val("t3_idle_after_stop", cur_sig(), 23'd0);

    // T4: full 64-entry table, start ignored mid-song, start+stop in IDLE
    for (int i = 0; i < 64; i++) rom[i] = note(100, 1);
    push(0, 0, 0, 1, 0, -1);
    push(0, 100, 1, 1, 0, 2);
`ifdef SEQ_ARTICULATION_EN
    for (int k = 0; k < 63; k++) begin
      push(k + 1, 0, 0, 1, 0, 32);
      push(k + 1, 100, 1, 1, 0, 322);
    end
    push(0, 0, 0, 1, 1, 32);
    push(0, 0, 0, 0, 0, 1);
    S = 34 + 354 * 63 + 1;
`else
    for (int k = 1; k < 64; k++) push(k, 100, 1, 1, 0, (k == 1) ? 32 : 34);
    push(0, 0, 0, 1, 1, 34);
    push(0, 0, 0, 0, 0, 1);
    S = 2177;
`endif
    pulse_start(E);
    wait_until(E + 500);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_until(E + S + 5);
    check_drained("t4_full_table");
    @(negedge clk) begin start = 1'b1; stop = 1'b1; end
    @(negedge clk) begin start = 1'b0; stop = 1'b0; end
    repeat (5) @(negedge clk);
    check_val("t4_start_stop_idle", cur_sig(), 23'd0);
    check_drained("t4_no_events_idle");

    // T5: async reset mid-PLAY, then restart from address 0
    clear_rom();
    rom[0] = note(262, 1);
    rom[1] = note(0, 1);
    push(0, 0, 0, 1, 0, -1);
    push(0, 262, 1, 1, 0, 2);
    push(0, 0, 0, 0, 0, 8);
    pulse_start(E);
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_val("t5_async_reset", cur_sig(), 23'd0);
    @(negedge clk) reset_n = 1'b1;
    push(0, 0, 0, 1, 0, -1);
    push(0, 262, 1, 1, 0, 2);
    push(0, 0, 0, 0, 0, 3);
    pulse_start(E);
    stop_at(E + 5);
    wait_until(E + 10);
    check_drained("t5_restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
